// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and default widths for the DMA write scheduler.
//   state_e      : scheduler FSM state (IDLE accepts a beat, ISSUE drives AXI)
//   DEF_*_W      : default address / data / awuser widths
//   BEAT_BYTES   : bytes carried by one single-beat write at the default width
// -----------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_USER_W = 16;
    localparam int BEAT_BYTES = DEF_DATA_W / 8;

endpackage

// File: rtl/dma_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dma_rr_arbiter
// Combinational round-robin pick: grants the first asserted request found by
// searching upward from ptr_i, wrapping at NREQ.
//   req_i        in   NREQ   request vector
//   ptr_i        in   PTR_W  highest-priority index this cycle (must be < NREQ)
//   grant_o      out  NREQ   one-hot grant, all zero when no request
//   grant_idx_o  out  PTR_W  binary index of the granted request
//   grant_any_o  out  1      some request was granted
// -----------------------------------------------------------------------------
module dma_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             grant_any_o
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int               SUM_W  = PTR_W + 1;
    localparam logic [SUM_W-1:0] NREQ_V = SUM_W'(NREQ);

    logic [SUM_W-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + SUM_W'(k);
            if (cand >= NREQ_V) begin
                cand = cand - NREQ_V;
            end
            if (!grant_any_o && req_i[cand[PTR_W-1:0]]) begin
                grant_o[cand[PTR_W-1:0]] = 1'b1;
                grant_idx_o              = cand[PTR_W-1:0];
                grant_any_o              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_wr_sched.sv
// -----------------------------------------------------------------------------
// dma_wr_sched
// Round-robin scheduler of single-beat AXI writes from NREQ DMA requesters onto
// one AW/W path. The granted requester's DSid rides on awuser. AW and W are
// tracked independently; a beat completes once both have handshaken. Each
// requester has a sticky completion interrupt and a 32-bit beat counter.
//   clk, reset         clock, synchronous active-high reset
//   req_valid/ready    per-requester beat handshake (ready is one-hot)
//   req_addr/data/dsid packed per-requester payload, req_last marks end
//   axi_aw*            AW channel (awaddr, awuser = DSid)
//   axi_w*             W channel
//   done_intr          sticky "last beat written" flag per requester
//   intr_clr           clears done_intr[i] and beat_cnt[i]
//   beat_cnt           packed 32-bit completed-beat counters
// -----------------------------------------------------------------------------
module dma_wr_sched
    import dma_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int USER_W = DEF_USER_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*USER_W-1:0] req_dsid,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [ADDR_W-1:0]      axi_awaddr,
    output logic [USER_W-1:0]      axi_awuser,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    output logic [DATA_W-1:0]      axi_wdata,
    output logic [NREQ-1:0]        done_intr,
    input  logic [NREQ-1:0]        intr_clr,
    output logic [NREQ*32-1:0]     beat_cnt
);

    localparam int               PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    // Unpacked views of the packed requester buses.
    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
    logic [USER_W-1:0] dsid_a [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_a[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
        assign dsid_a[gi] = req_dsid[gi*USER_W +: USER_W];
    end

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic              aw_ok_q, aw_ok_d;
    logic              w_ok_q, w_ok_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [USER_W-1:0] user_q, user_d;
    logic              last_q, last_d;
    logic [PTR_W-1:0]  idx_q, idx_d;

    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic              aw_done;
    logic              w_done;
    logic              beat_done;

    dma_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        aw_ok_d     = aw_ok_q;
        w_ok_d      = w_ok_q;
        addr_d      = addr_q;
        data_d      = data_q;
        user_d      = user_q;
        last_d      = last_q;
        idx_d       = idx_q;
        req_ready   = '0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        aw_done     = 1'b0;
        w_done      = 1'b0;
        beat_done   = 1'b0;

        case (state_q)
            IDLE: begin
                // Suppress ready during reset so no requester believes a beat
                // was taken that reset is about to discard.
                if (!reset && grant_any) begin
                    req_ready = grant;
                    addr_d    = addr_a[grant_idx];
                    data_d    = data_a[grant_idx];
                    user_d    = dsid_a[grant_idx];
                    last_d    = req_last[grant_idx];
                    idx_d     = grant_idx;
                    rr_d      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                axi_awvalid = ~aw_ok_q;
                axi_wvalid  = ~w_ok_q;
                // A channel counts as done if it finished earlier or
                // handshakes right now (valid is high whenever ok is low).
                aw_done     = aw_ok_q | axi_awready;
                w_done      = w_ok_q | axi_wready;
                if (aw_done && w_done) begin
                    beat_done = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    aw_ok_d   = aw_done;
                    w_ok_d    = w_done;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            aw_ok_q <= 1'b0;
            w_ok_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            aw_ok_q <= aw_ok_d;
            w_ok_q  <= w_ok_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign axi_awaddr = addr_q;
    assign axi_awuser = user_q;
    assign axi_wdata  = data_q;

    // Per-requester completion flag and beat counter. A completing beat takes
    // precedence over a clear: the flag stays set, the counter restarts at 1.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic        hit;
        logic        done_q;
        logic [31:0] cnt_q;

        assign hit = beat_done && (idx_q == PTR_W'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                done_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                if (hit) begin
                    cnt_q <= intr_clr[gi] ? 32'd1 : cnt_q + 32'd1;
                end else if (intr_clr[gi]) begin
                    cnt_q <= '0;
                end

                if (hit && last_q) begin
                    done_q <= 1'b1;
                end else if (intr_clr[gi]) begin
                    done_q <= 1'b0;
                end
            end
        end

        assign done_intr[gi]           = done_q;
        assign beat_cnt[gi*32 +: 32]   = cnt_q;
    end

endmodule

// File: tb/tb_dma_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_dma_wr_sched
// Directed bench for dma_wr_sched (NREQ=2, default widths). Inputs change
// 1 time unit after the rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_dma_wr_sched;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int USER_W = 16;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*USER_W-1:0] req_dsid;
    logic                   axi_awvalid;
    logic                   axi_awready;
    logic [ADDR_W-1:0]      axi_awaddr;
    logic [USER_W-1:0]      axi_awuser;
    logic                   axi_wvalid;
    logic                   axi_wready;
    logic [DATA_W-1:0]      axi_wdata;
    logic [NREQ-1:0]        done_intr;
    logic [NREQ-1:0]        intr_clr;
    logic [NREQ*32-1:0]     beat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dma_wr_sched #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .USER_W (USER_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_dsid    (req_dsid),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_awuser  (axi_awuser),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wdata   (axi_wdata),
        .done_intr   (done_intr),
        .intr_clr    (intr_clr),
        .beat_cnt    (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int c1;
        int g;
        logic seen_v;
        logic seen_r;

        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        req_last    = '0;
        req_dsid    = '0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        intr_clr    = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;

        // ---- reset state
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", done_intr, 0);
        chk("rst_cnt", beat_cnt, 0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_awuser", axi_awuser, 0);
        chk("rst_wdata", axi_wdata, 0);

        // ---- single beat, immediate handshakes
        req_addr[0 +: 32]  = 32'h8000_0000;
        req_data[0 +: 64]  = 64'h1122_3344_5566_7788;
        req_dsid[0 +: 16]  = 16'd1;
        req_last           = 2'b01;
        req_valid          = 2'b01;
        axi_awready        = 1'b1;
        axi_wready         = 1'b1;
        #1;
        chk("t1_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        chk("t1_awvalid", axi_awvalid, 1);
        chk("t1_wvalid", axi_wvalid, 1);
        chk("t1_awaddr", axi_awaddr, 32'h8000_0000);
        chk("t1_wdata", axi_wdata, 64'h1122_3344_5566_7788);
        chk("t1_awuser", axi_awuser, 1);
        cyc();
        chk("t1_awvalid_off", axi_awvalid, 0);
        chk("t1_wvalid_off", axi_wvalid, 0);
        chk("t1_done", done_intr, 2'b01);
        chk("t1_cnt0", beat_cnt[0 +: 32], 1);

        // ---- W delayed, AW immediate
        req_addr[0 +: 32] = 32'h8000_0008;
        req_data[0 +: 64] = 64'hCAFE_0000_0000_0001;
        req_last          = 2'b00;
        axi_awready       = 1'b1;
        axi_wready        = 1'b0;
        req_valid         = 2'b01;
        cyc();
        req_valid = '0;
        chk("wdly_awvalid0", axi_awvalid, 1);
        chk("wdly_wvalid0", axi_wvalid, 1);
        cyc();
        chk("wdly_aw_dropped", axi_awvalid, 0);
        chk("wdly_wvalid1", axi_wvalid, 1);
        repeat (3) cyc();
        chk("wdly_wvalid_held", axi_wvalid, 1);
        chk("wdly_wdata_held", axi_wdata, 64'hCAFE_0000_0000_0001);
        chk("wdly_cnt_pending", beat_cnt[0 +: 32], 1);
        axi_wready = 1'b1;
        cyc();
        chk("wdly_wvalid_off", axi_wvalid, 0);
        chk("wdly_cnt0", beat_cnt[0 +: 32], 2);
        cyc();
        chk("wdly_cnt_once", beat_cnt[0 +: 32], 2);
        chk("wdly_awvalid_idle", axi_awvalid, 0);

        // ---- AW delayed, W immediate
        req_addr[0 +: 32] = 32'h8000_0010;
        req_data[0 +: 64] = 64'hCAFE_0000_0000_0002;
        axi_awready       = 1'b0;
        axi_wready        = 1'b1;
        req_valid         = 2'b01;
        cyc();
        req_valid = '0;
        cyc();
        chk("awdly_awvalid", axi_awvalid, 1);
        chk("awdly_w_dropped", axi_wvalid, 0);
        repeat (3) cyc();
        chk("awdly_awaddr_held", axi_awaddr, 32'h8000_0010);
        chk("awdly_awvalid_held", axi_awvalid, 1);
        axi_awready = 1'b1;
        cyc();
        chk("awdly_awvalid_off", axi_awvalid, 0);
        chk("awdly_cnt0", beat_cnt[0 +: 32], 3);

        // ---- clear, then both channels late and completing together, last
        intr_clr = 2'b01;
        cyc();
        intr_clr = '0;
        chk("clr_done", done_intr, 0);
        chk("clr_cnt0", beat_cnt[0 +: 32], 0);
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        req_last    = 2'b01;
        req_valid   = 2'b01;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("both_awvalid", axi_awvalid, 1);
        chk("both_wvalid", axi_wvalid, 1);
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        cyc();
        chk("both_awvalid_off", axi_awvalid, 0);
        chk("both_wvalid_off", axi_wvalid, 0);
        chk("both_done", done_intr, 2'b01);
        chk("both_cnt0", beat_cnt[0 +: 32], 1);

        // ---- reset mid-beat (pointer was moved to 1 by this accept)
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        req_last    = 2'b00;
        req_valid   = 2'b01;
        cyc();
        req_valid = '0;
        chk("mid_awvalid_pre", axi_awvalid, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("mid_awvalid", axi_awvalid, 0);
        chk("mid_wvalid", axi_wvalid, 0);
        chk("mid_done", done_intr, 0);
        chk("mid_cnt", beat_cnt, 0);
        chk("mid_awaddr", axi_awaddr, 0);

        // ---- contention: 6 beats each, grants must alternate from 0
        req_addr[0 +: 32]  = 32'h8000_1000;
        req_addr[32 +: 32] = 32'h9000_2000;
        req_data[0 +: 64]  = 64'hAAAA_0000_0000_0000;
        req_data[64 +: 64] = 64'hBBBB_0000_0000_0000;
        req_dsid[0 +: 16]  = 16'h000A;
        req_dsid[16 +: 16] = 16'h000B;
        axi_awready        = 1'b1;
        axi_wready         = 1'b1;
        req_valid          = 2'b11;
        c0 = 0;
        c1 = 0;
        for (int b = 0; b < 12; b++) begin
            g = b % 2;
            req_last[0] = (c0 == 5);
            req_last[1] = (c1 == 5);
            #1;
            chk("rr_grant", req_ready, (g == 0) ? 2'b01 : 2'b10);
            cyc();
            if (g == 0) begin
                c0++;
                if (c0 == 6) req_valid[0] = 1'b0;
            end else begin
                c1++;
                if (c1 == 6) req_valid[1] = 1'b0;
            end
            chk("rr_awuser", axi_awuser, (g == 0) ? 16'h000A : 16'h000B);
            chk("rr_awaddr", axi_awaddr, (g == 0) ? 32'h8000_1000 : 32'h9000_2000);
            chk("rr_wdata", axi_wdata, (g == 0) ? 64'hAAAA_0000_0000_0000 : 64'hBBBB_0000_0000_0000);
            cyc();
        end
        chk("rr_done", done_intr, 2'b11);
        chk("rr_cnt0", beat_cnt[0 +: 32], 6);
        chk("rr_cnt1", beat_cnt[32 +: 32], 6);

        // ---- clear race: clear coincides with completing last beat
        intr_clr = 2'b01;
        cyc();
        intr_clr = '0;
        chk("race_pre_done", done_intr, 2'b10);
        chk("race_pre_cnt0", beat_cnt[0 +: 32], 0);
        req_last  = 2'b00;
        req_valid = 2'b01;
        cyc();
        req_valid = '0;
        cyc();
        chk("race_cnt0_one", beat_cnt[0 +: 32], 1);
        req_last  = 2'b01;
        req_valid = 2'b01;
        cyc();
        req_valid = '0;
        intr_clr  = 2'b01;
        cyc();
        intr_clr = '0;
        chk("race_done", done_intr, 2'b11);
        chk("race_cnt0", beat_cnt[0 +: 32], 1);
        chk("race_cnt1", beat_cnt[32 +: 32], 6);

        // ---- idle: nothing requested for 100 cycles
        seen_v = 1'b0;
        seen_r = 1'b0;
        repeat (100) begin
            cyc();
            seen_v = seen_v | axi_awvalid | axi_wvalid;
            seen_r = seen_r | (|req_ready);
        end
        chk("idle_valids", seen_v, 0);
        chk("idle_ready", seen_r, 0);
        chk("idle_cnt1", beat_cnt[32 +: 32], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
